// File: rtl/fb_arbiter_if.sv
// Frame-buffer arbiter bus: write-request port and frame-buffer port.
// slave = arbiter side, master = requester/memory side.
interface fb_arbiter_if #(
    parameter int DW = 15
);
    logic          wr_req;
    logic [DW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          wr_ack;
    logic          mem_en;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [11:0]   mem_wdata;
    logic [11:0]   mem_rdata;

    modport slave (
        input  wr_req, wr_addr, wr_data, mem_rdata,
        output wr_ack, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output wr_req, wr_addr, wr_data, mem_rdata,
        input  wr_ack, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/fb_arbiter.sv
// Frame-buffer arbiter: scaled display reads have priority,
// writes fill the free cycles, one grant every other cycle.
module fb_arbiter #(
    parameter int DW    = 15,
    parameter int H_SRC = 200,
    parameter int V_SRC = 150,
    parameter int SCALE = 4
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        hen,
    input  logic        ven,
    fb_arbiter_if.slave bus,
    output logic [11:0] rgb
);
    localparam int SW = $clog2(SCALE);
    localparam int CW = $clog2(H_SRC);
    localparam int RW = $clog2(V_SRC);
    localparam logic [DW:0] NPIX = (DW + 1)'(H_SRC * V_SRC);

    logic [SW-1:0] sx;
    logic [SW-1:0] sy;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          hen_d;
    logic          disp;
    logic          slot;
    logic          grant;
    logic          in_range;
    logic [DW-1:0] raddr;
    logic [1:0]    slot_d;
    logic [2:0]    disp_d;
    logic [11:0]   pix;

    assign disp     = hen & ven;
    assign slot     = disp && (sx == '0);
    assign raddr    = DW'(row) * DW'(H_SRC) + DW'(col);
    assign grant    = !slot && bus.wr_req && !bus.wr_ack;
    assign in_range = {1'b0, bus.wr_addr} < NPIX;
    assign rgb      = disp_d[2] ? pix : 12'h000;

    // scan position: pixel/column along the line, line/row on hen fall
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hen_d <= 1'b0;
            sx    <= '0;
            col   <= '0;
            sy    <= '0;
            row   <= '0;
        end else begin
            hen_d <= hen;
            if (!ven) begin
                sx  <= '0;
                col <= '0;
                sy  <= '0;
                row <= '0;
            end else if (hen_d && !hen) begin
                sx  <= '0;
                col <= '0;
                if (sy == SW'(SCALE - 1)) begin
                    sy  <= '0;
                    row <= (row == RW'(V_SRC - 1)) ? '0 : row + 1'b1;
                end else begin
                    sy <= sy + 1'b1;
                end
            end else if (disp) begin
                if (sx == SW'(SCALE - 1)) begin
                    sx  <= '0;
                    col <= (col == CW'(H_SRC - 1)) ? '0 : col + 1'b1;
                end else begin
                    sx <= sx + 1'b1;
                end
            end
        end
    end

    // registered arbitration: read slot first, else a non-repeated write
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            bus.wr_ack    <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else if (slot) begin
            bus.wr_ack   <= 1'b0;
            bus.mem_en   <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= raddr;
        end else if (grant) begin
            bus.wr_ack    <= 1'b1;
            bus.mem_en    <= in_range;
            bus.mem_we    <= in_range;
            bus.mem_addr  <= bus.wr_addr;
            bus.mem_wdata <= bus.wr_data;
        end else begin
            bus.wr_ack <= 1'b0;
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
        end
    end

    // pixel pipeline: capture read data, blank via delayed display flag
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            slot_d <= '0;
            disp_d <= '0;
            pix    <= '0;
        end else begin
            slot_d <= {slot_d[0], slot};
            disp_d <= {disp_d[1:0], disp};
            if (slot_d[1]) begin
                pix <= bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboard bench for fb_arbiter with default geometry
// and a synchronous frame-buffer model.
module tb_fb_arbiter;
    localparam int DW   = 15;
    localparam int H    = 200;
    localparam int V    = 150;
    localparam int S    = 4;
    localparam int NPIX = H * V;

    typedef struct {
        logic [DW-1:0] addr;
        logic [11:0]   data;
        bit            oor;
    } wr_t;

    logic        pclk = 1'b0;
    logic        rst;
    logic        hen;
    logic        ven;
    logic [11:0] rgb;

    fb_arbiter_if #(.DW(DW)) bus ();

    fb_arbiter #(
        .DW(DW), .H_SRC(H), .V_SRC(V), .SCALE(S)
    ) dut (
        .pclk(pclk), .rst(rst), .hen(hen), .ven(ven),
        .bus(bus), .rgb(rgb)
    );

    always #5 pclk = ~pclk;

    int          total = 0;
    int          bad   = 0;
    int          nack  = 0;
    int          rd_q[$];
    logic [11:0] rgb_q[$];
    wr_t         wr_q[$];
    logic [11:0] mem[0:32767];
    logic [11:0] shadow[0:32767];
    bit          ram_init = 1'b0;

    function automatic logic [11:0] pat(input int i);
        return 12'(i * 37 + 5);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // frame-buffer model: read data valid the cycle after the request
    always @(posedge pclk) begin
        if (!ram_init) begin
            for (int i = 0; i < 32768; i++) mem[i] <= pat(i);
            ram_init <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    // monitor: pops expectations whenever the DUT presents an output
    logic [2:0] dh = 3'b000;
    bit         prev_ack = 1'b0;
    wr_t        me;
    always @(negedge pclk) begin
        if (rst) begin
            dh = 3'b000;
            prev_ack = 1'b0;
            chk("rst_ctl", 32'({bus.wr_ack, bus.mem_en, bus.mem_we}), 0);
            chk("rst_addr", 32'(bus.mem_addr), 0);
            chk("rst_data", 32'({bus.mem_wdata, rgb}), 0);
        end else begin
            if (bus.mem_en && !bus.mem_we) begin
                chk("rd_pending", 32'(rd_q.size() > 0), 1);
                chk("rd_ack_clash", 32'(bus.wr_ack), 0);
                if (rd_q.size() > 0)
                    chk("rd_addr", 32'(bus.mem_addr), 32'(rd_q.pop_front()));
            end
            if (bus.wr_ack) begin
                nack++;
                chk("ack_gap", 32'(prev_ack), 0);
                chk("ack_pending", 32'(wr_q.size() > 0), 1);
                if (wr_q.size() > 0) begin
                    me = wr_q.pop_front();
                    chk("wr_en_we", 32'({bus.mem_en, bus.mem_we}),
                        me.oor ? 0 : 3);
                    if (!me.oor) begin
                        chk("wr_addr", 32'(bus.mem_addr), 32'(me.addr));
                        chk("wr_data", 32'(bus.mem_wdata), 32'(me.data));
                    end
                end
            end else begin
                chk("we_no_ack", 32'(bus.mem_we), 0);
            end
            prev_ack = bus.wr_ack;
            if (dh[2]) begin
                chk("rgb_pending", 32'(rgb_q.size() > 0), 1);
                if (rgb_q.size() > 0)
                    chk("rgb", 32'(rgb), 32'(rgb_q.pop_front()));
            end else begin
                chk("rgb_blank", 32'(rgb), 0);
            end
            dh = {dh[1:0], hen & ven};
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // n display cycles of a line at source row r; tail drops hen
    task automatic line(input int n, input int r, input bit tail);
        for (int j = 0; j < n; j++) begin
            int a;
            a = r * H + (j / S) % H;
            hen = 1'b1;
            ven = 1'b1;
            if (j % S == 0) rd_q.push_back(a);
            rgb_q.push_back(shadow[a]);
            tick();
        end
        if (tail) begin
            hen = 1'b0;
            tick();
            tick();
        end
    endtask

    // held write request, released once acknowledged
    task automatic wr(input int a, input int d);
        wr_t e;
        int  k;
        bus.wr_req  = 1'b1;
        bus.wr_addr = DW'(a);
        bus.wr_data = 12'(d);
        e.addr = DW'(a);
        e.data = 12'(d);
        e.oor  = (a >= NPIX);
        wr_q.push_back(e);
        if (!e.oor) shadow[a] = 12'(d);
        k = 0;
        forever begin
            @(negedge pclk);
            if (bus.wr_ack) break;
            k++;
            if (k >= 50) break;
        end
        chk("wr_timeout", 32'(bus.wr_ack), 1);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nack0;
        rst = 1'b1;
        hen = 1'b0;
        ven = 1'b0;
        bus.wr_req  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        for (int i = 0; i < 32768; i++) shadow[i] = pat(i);
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // first line with a held write stream, then an out-of-range write
        nack0 = nack;
        fork
            begin
                line(4 * H, 0, 1'b1);
                chk("wr_rate", 32'(nack - nack0 >= 301), 1);
            end
            begin
                for (int i = 0; i < 300; i++) wr(10000 + i, i * 5 + 1);
                wr(30000, 12'hABC);
                bus.wr_req = 1'b0;
            end
        join
        chk("wr_count", 32'(nack - nack0), 301);

        // lines 1..4: row advances once after four hen falls
        for (int l = 1; l < 4; l++) line(8, 0, 1'b1);
        line(8, 1, 1'b1);

        // rest of the frame with one-pixel lines, last line full width
        for (int l = 5; l < 599; l++) line(1, l / 4, 1'b1);
        line(4 * H, 149, 1'b1);
        line(8, 0, 1'b1);
        ven = 1'b0;
        repeat (4) tick();

        // reset mid-line with a write request pending
        line(41, 0, 1'b0);
        bus.wr_req  = 1'b1;
        bus.wr_addr = DW'(5);
        bus.wr_data = 12'h777;
        #1;
        rst = 1'b1;
        rd_q.delete();
        wr_q.delete();
        rgb_q.delete();
        hen = 1'b0;
        ven = 1'b0;
        #1;
        chk("rst_now_ctl", 32'({bus.wr_ack, bus.mem_en, bus.mem_we}), 0);
        chk("rst_now_addr", 32'(bus.mem_addr), 0);
        chk("rst_now_data", 32'({bus.mem_wdata, rgb}), 0);
        tick();
        tick();
        bus.wr_req = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        line(16, 0, 1'b1);
        ven = 1'b0;
        repeat (6) tick();

        chk("rd_q_empty", 32'(rd_q.size()), 0);
        chk("wr_q_empty", 32'(wr_q.size()), 0);
        chk("rgb_q_empty", 32'(rgb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
